// File: rtl/rtc_bus_responder.sv
// rtc_bus_responder: RTC-chip stand-in on the date/time register bus.
// Decodes chip-select / RD / WR cycles against a BCD time/date register
// bank, returns read data or commits validated write data, and advances
// sec/min/hour on a 1 s tick.
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   dir_in[7:0]        register address (latched on camb_fecha rise)
//   camb_fecha         chip select, bus cycle active while high
//   RD, WR             read / write strobes, active high
//   data_in[7:0]       BCD write data
//   tick_1s            one-cycle pulse, advance time by one second
//   data_out[7:0]      read data, held until the next read
//   rd_valid           one-cycle pulse, data_out updated
//   wr_done            one-cycle pulse, write committed
//   err                one-cycle pulse, unmapped address or bad BCD value
module rtc_bus_responder #(
   parameter logic [7:0] ADDR_SEC   = 8'd0,
   parameter logic [7:0] ADDR_MIN   = 8'd1,
   parameter logic [7:0] ADDR_HOUR  = 8'd2,
   parameter logic [7:0] ADDR_DAY   = 8'd8,
   parameter logic [7:0] ADDR_MONTH = 8'd9,
   parameter logic [7:0] ADDR_YEAR  = 8'd10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] dir_in,
   input  logic       camb_fecha,
   input  logic       RD,
   input  logic       WR,
   input  logic [7:0] data_in,
   input  logic       tick_1s,
   output logic [7:0] data_out,
   output logic       rd_valid,
   output logic       wr_done,
   output logic       err
);

   localparam int unsigned DW = 8;

   typedef enum logic [1:0] {IDLE, SEL, RDH, WRH} state_t;

   state_t        state, state_n;
   logic [DW-1:0] addr_q, addr_n;
   logic [DW-1:0] wr_buf, wr_buf_n;
   logic          rd_first, rd_first_n;
   logic          camb_q, rd_q, wr_q;
   logic          tick_pend, tick_pend_n;
   logic [DW-1:0] sec, min, hour, day, month, year;
   logic [DW-1:0] sec_n, min_n, hour_n, day_n, month_n, year_n;
   logic [DW-1:0] data_out_n;
   logic          rd_valid_n, wr_done_n, err_n;

   logic [DW-1:0] rd_mux_c, lo_c, hi_c;
   logic          mapped_c, wr_ok_c, commit_c, apply_tick_c;
   logic          camb_rise, camb_fall, rd_rise, rd_fall, wr_rise, wr_fall;

   // BCD +1 without wrap; callers handle the wrap point
   function automatic logic [DW-1:0] bcd_inc(input logic [DW-1:0] v);
      if (v[3:0] == 4'd9) return {4'(v[7:4] + 4'd1), 4'd0};
      else                return {v[7:4], 4'(v[3:0] + 4'd1)};
   endfunction

   assign camb_rise = camb_fecha & ~camb_q;
   assign camb_fall = ~camb_fecha & camb_q;
   assign rd_rise   = RD & ~rd_q & camb_fecha;
   assign rd_fall   = ~RD & rd_q;
   assign wr_rise   = WR & ~wr_q & camb_fecha;
   assign wr_fall   = ~WR & wr_q;

   // Address decode: read mux plus legal BCD range for the latched address
   always_comb begin
      rd_mux_c = '0;
      lo_c     = '0;
      hi_c     = '0;
      mapped_c = 1'b1;
      if (addr_q == ADDR_SEC) begin
         rd_mux_c = sec;   hi_c = 8'h59;
      end else if (addr_q == ADDR_MIN) begin
         rd_mux_c = min;   hi_c = 8'h59;
      end else if (addr_q == ADDR_HOUR) begin
         rd_mux_c = hour;  hi_c = 8'h23;
      end else if (addr_q == ADDR_DAY) begin
         rd_mux_c = day;   lo_c = 8'h01; hi_c = 8'h31;
      end else if (addr_q == ADDR_MONTH) begin
         rd_mux_c = month; lo_c = 8'h01; hi_c = 8'h12;
      end else if (addr_q == ADDR_YEAR) begin
         rd_mux_c = year;  hi_c = 8'h99;
      end else begin
         mapped_c = 1'b0;
      end
   end

   // Nibble check first, so a plain numeric compare is a valid BCD compare
   assign wr_ok_c = mapped_c && (wr_buf[3:0] <= 4'd9) && (wr_buf[7:4] <= 4'd9)
                    && (wr_buf >= lo_c) && (wr_buf <= hi_c);

   // Next-state, outputs, register bank and tick handling
   always_comb begin
      state_n     = state;
      addr_n      = addr_q;
      wr_buf_n    = wr_buf;
      rd_first_n  = 1'b0;
      data_out_n  = data_out;
      rd_valid_n  = 1'b0;
      wr_done_n   = 1'b0;
      err_n       = 1'b0;
      commit_c    = 1'b0;
      sec_n       = sec;
      min_n       = min;
      hour_n      = hour;
      day_n       = day;
      month_n     = month;
      year_n      = year;

      case (state)
         IDLE: begin
            if (camb_rise) begin
               addr_n  = dir_in;
               state_n = SEL;
            end
         end
         SEL: begin
            if (camb_fall) begin
               state_n = IDLE;
            end else if (rd_rise) begin
               state_n    = RDH;
               rd_first_n = 1'b1;
            end else if (wr_rise) begin
               state_n  = WRH;
               wr_buf_n = data_in;
            end
         end
         RDH: begin
            if (camb_fall) begin
               state_n = IDLE;
            end else begin
               if (rd_first) begin
                  data_out_n = rd_mux_c;
                  rd_valid_n = 1'b1;
                  err_n      = ~mapped_c;
               end
               if (rd_fall) state_n = SEL;
            end
         end
         WRH: begin
            if (WR) wr_buf_n = data_in;
            // A WR fall wins over a same-cycle chip-select fall
            if (wr_fall) begin
               commit_c  = wr_ok_c;
               wr_done_n = wr_ok_c;
               err_n     = ~wr_ok_c;
               state_n   = camb_fall ? IDLE : SEL;
            end else if (camb_fall) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase

      // A commit cycle defers any tick by one cycle via tick_pend
      apply_tick_c = (tick_1s | tick_pend) & ~commit_c;
      tick_pend_n  = commit_c ? (tick_pend | tick_1s) : (tick_1s & tick_pend);

      if (apply_tick_c) begin
         if (sec == 8'h59) begin
            sec_n = 8'h00;
            if (min == 8'h59) begin
               min_n  = 8'h00;
               hour_n = (hour == 8'h23) ? 8'h00 : bcd_inc(hour);
            end else begin
               min_n = bcd_inc(min);
            end
         end else begin
            sec_n = bcd_inc(sec);
         end
      end

      if (commit_c) begin
         if      (addr_q == ADDR_SEC)   sec_n   = wr_buf;
         else if (addr_q == ADDR_MIN)   min_n   = wr_buf;
         else if (addr_q == ADDR_HOUR)  hour_n  = wr_buf;
         else if (addr_q == ADDR_DAY)   day_n   = wr_buf;
         else if (addr_q == ADDR_MONTH) month_n = wr_buf;
         else if (addr_q == ADDR_YEAR)  year_n  = wr_buf;
      end
   end

   // State, edge-detect history, register bank and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         addr_q    <= '0;
         wr_buf    <= '0;
         rd_first  <= 1'b0;
         camb_q    <= 1'b0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         tick_pend <= 1'b0;
         sec       <= 8'h00;
         min       <= 8'h00;
         hour      <= 8'h00;
         day       <= 8'h01;
         month     <= 8'h01;
         year      <= 8'h00;
         data_out  <= '0;
         rd_valid  <= 1'b0;
         wr_done   <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_n;
         addr_q    <= addr_n;
         wr_buf    <= wr_buf_n;
         rd_first  <= rd_first_n;
         camb_q    <= camb_fecha;
         rd_q      <= RD;
         wr_q      <= WR;
         tick_pend <= tick_pend_n;
         sec       <= sec_n;
         min       <= min_n;
         hour      <= hour_n;
         day       <= day_n;
         month     <= month_n;
         year      <= year_n;
         data_out  <= data_out_n;
         rd_valid  <= rd_valid_n;
         wr_done   <= wr_done_n;
         err       <= err_n;
      end
   end

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Self-checking bench for rtc_bus_responder: directed vector table,
// hand-written corner sequences, then random traffic against a
// seconds-of-day reference model.
module tb_rtc_bus_responder;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] dir_in;
   logic       camb_fecha;
   logic       RD;
   logic       WR;
   logic [7:0] data_in;
   logic       tick_1s;
   logic [7:0] data_out;
   logic       rd_valid;
   logic       wr_done;
   logic       err;

   rtc_bus_responder dut (
      .clk(clk), .reset(reset), .dir_in(dir_in), .camb_fecha(camb_fecha),
      .RD(RD), .WR(WR), .data_in(data_in), .tick_1s(tick_1s),
      .data_out(data_out), .rd_valid(rd_valid), .wr_done(wr_done), .err(err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: time as seconds since midnight, date as BCD bytes
   int         t_sec;
   logic [7:0] m_day, m_month, m_year;

   typedef struct {
      int         op;      // 0 read, 1 write, 2 tick
      logic [7:0] addr;
      logic [7:0] din;
      logic [7:0] exp_d;
      logic       exp_ok;  // write committed
      logic       exp_err;
      int         hold;
   } vec_t;

   vec_t vecs[21];

   logic [7:0] addr_list[6] = '{8'd0, 8'd1, 8'd2, 8'd8, 8'd9, 8'd10};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   function automatic logic [7:0] to_bcd(input int n);
      logic [7:0] r;
      r[7:4] = 4'(n / 10);
      r[3:0] = 4'(n % 10);
      return r;
   endfunction

   function automatic int from_bcd(input logic [7:0] v);
      return int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   function automatic void model_reset();
      t_sec = 0; m_day = 8'h01; m_month = 8'h01; m_year = 8'h00;
   endfunction

   function automatic void model_tick();
      t_sec = (t_sec + 1) % 86400;
   endfunction

   // {err, data}
   function automatic logic [8:0] model_read(input logic [7:0] a);
      case (a)
         8'd0:    return {1'b0, to_bcd(t_sec % 60)};
         8'd1:    return {1'b0, to_bcd((t_sec / 60) % 60)};
         8'd2:    return {1'b0, to_bcd(t_sec / 3600)};
         8'd8:    return {1'b0, m_day};
         8'd9:    return {1'b0, m_month};
         8'd10:   return {1'b0, m_year};
         default: return {1'b1, 8'h00};
      endcase
   endfunction

   function automatic logic model_write(input logic [7:0] a, input logic [7:0] v);
      int n;
      if (v[7:4] > 4'd9 || v[3:0] > 4'd9) return 1'b0;
      n = from_bcd(v);
      case (a)
         8'd0:  if (n <= 59) begin t_sec = t_sec - t_sec % 60 + n; return 1'b1; end
         8'd1:  if (n <= 59) begin t_sec = t_sec - ((t_sec / 60) % 60) * 60 + n * 60; return 1'b1; end
         8'd2:  if (n <= 23) begin t_sec = t_sec % 3600 + n * 3600; return 1'b1; end
         8'd8:  if (n >= 1 && n <= 31) begin m_day = v; return 1'b1; end
         8'd9:  if (n >= 1 && n <= 12) begin m_month = v; return 1'b1; end
         8'd10: begin m_year = v; return 1'b1; end
         default: ;
      endcase
      return 1'b0;
   endfunction

   // Full read cycle; checks data, err, 2-clk latency and single pulse width
   task automatic do_read(input string nm, input logic [7:0] a, input int hold,
                          input logic [7:0] exp_d, input logic exp_err);
      int lat, pulses;
      logic [7:0] d;
      logic e;
      lat = -1; pulses = 0; d = 8'h00; e = 1'b0;
      camb_fecha = 1'b1; dir_in = a;
      step();
      RD = 1'b1;
      for (int c = 1; c <= hold + 3; c++) begin
         if (c == hold + 1) RD = 1'b0;
         step();
         if (rd_valid) begin
            pulses++;
            if (lat < 0) begin lat = c; d = data_out; e = err; end
         end
      end
      camb_fecha = 1'b0;
      step();
      chk({nm, " data"}, 32'(d), 32'(exp_d));
      chk({nm, " err"}, 32'(e), 32'(exp_err));
      chk({nm, " latency"}, 32'(lat), 32'd2);
      chk({nm, " pulses"}, 32'(pulses), 32'd1);
   endtask

   // Full write cycle; optional chip-select drop mid-WR, optional tick at commit
   task automatic do_write(input string nm, input logic [7:0] a, input logic [7:0] v,
                           input int hold, input logic drop, input logic tk,
                           input logic exp_done, input logic exp_err);
      logic done, e;
      int extra;
      extra = 0;
      camb_fecha = 1'b1; dir_in = a;
      step();
      WR = 1'b1; data_in = v;
      repeat (hold) step();
      if (drop) begin
         camb_fecha = 1'b0;
         step();
      end
      WR = 1'b0; tick_1s = tk;
      step();
      tick_1s = 1'b0;
      done = wr_done; e = err;
      repeat (2) begin
         step();
         if (wr_done || err) extra++;
      end
      camb_fecha = 1'b0;
      step();
      chk({nm, " wr_done"}, 32'(done), 32'(exp_done));
      chk({nm, " err"}, 32'(e), 32'(exp_err));
      chk({nm, " extra pulses"}, 32'(extra), 32'd0);
   endtask

   task automatic do_tick();
      tick_1s = 1'b1;
      step();
      tick_1s = 1'b0;
   endtask

   int         kind, hold, ntick, pulses;
   logic [7:0] ra, rv;
   logic [8:0] mr;
   logic       rtk, mok;

   initial begin
      reset = 1'b1; dir_in = '0; camb_fecha = 1'b0; RD = 1'b0; WR = 1'b0;
      data_in = '0; tick_1s = 1'b0;
      repeat (2) step();
      chk("reset data_out", 32'(data_out), 32'h0);
      chk("reset rd_valid", 32'(rd_valid), 32'h0);
      chk("reset wr_done", 32'(wr_done), 32'h0);
      chk("reset err", 32'(err), 32'h0);
      reset = 1'b0;
      step();

      // op, addr, din, exp_d, exp_ok, exp_err, hold
      vecs[0]  = '{0, 8'd9,  8'h00, 8'h01, 1'b0, 1'b0, 257};
      vecs[1]  = '{1, 8'd10, 8'h17, 8'h00, 1'b1, 1'b0, 256};
      vecs[2]  = '{0, 8'd10, 8'h00, 8'h17, 1'b0, 1'b0, 2};
      vecs[3]  = '{1, 8'd9,  8'h13, 8'h00, 1'b0, 1'b1, 3};
      vecs[4]  = '{0, 8'd9,  8'h00, 8'h01, 1'b0, 1'b0, 1};
      vecs[5]  = '{0, 8'd5,  8'h00, 8'h00, 1'b0, 1'b1, 2};
      vecs[6]  = '{1, 8'd2,  8'h23, 8'h00, 1'b1, 1'b0, 2};
      vecs[7]  = '{1, 8'd1,  8'h59, 8'h00, 1'b1, 1'b0, 1};
      vecs[8]  = '{1, 8'd0,  8'h59, 8'h00, 1'b1, 1'b0, 2};
      vecs[9]  = '{2, 8'd0,  8'h00, 8'h00, 1'b0, 1'b0, 0};
      vecs[10] = '{0, 8'd0,  8'h00, 8'h00, 1'b0, 1'b0, 2};
      vecs[11] = '{0, 8'd1,  8'h00, 8'h00, 1'b0, 1'b0, 2};
      vecs[12] = '{0, 8'd2,  8'h00, 8'h00, 1'b0, 1'b0, 2};
      vecs[13] = '{0, 8'd8,  8'h00, 8'h01, 1'b0, 1'b0, 2};
      vecs[14] = '{1, 8'd0,  8'h5A, 8'h00, 1'b0, 1'b1, 2};
      vecs[15] = '{1, 8'd8,  8'h00, 8'h00, 1'b0, 1'b1, 2};
      vecs[16] = '{1, 8'd8,  8'h31, 8'h00, 1'b1, 1'b0, 2};
      vecs[17] = '{0, 8'd8,  8'h00, 8'h31, 1'b0, 1'b0, 3};
      vecs[18] = '{1, 8'd2,  8'h24, 8'h00, 1'b0, 1'b1, 2};
      vecs[19] = '{1, 8'd3,  8'h00, 8'h00, 1'b0, 1'b1, 2};
      vecs[20] = '{0, 8'd2,  8'h00, 8'h00, 1'b0, 1'b0, 2};

      for (int i = 0; i < 21; i++) begin
         string nm;
         nm = $sformatf("vec%0d", i);
         case (vecs[i].op)
            0: do_read(nm, vecs[i].addr, vecs[i].hold, vecs[i].exp_d, vecs[i].exp_err);
            1: do_write(nm, vecs[i].addr, vecs[i].din, vecs[i].hold, 1'b0, 1'b0,
                        vecs[i].exp_ok, vecs[i].exp_err);
            default: begin do_tick(); step(); end
         endcase
      end

      // Commit and tick in the same cycle: tick lands one cycle later
      do_write("collide", 8'd0, 8'h30, 2, 1'b0, 1'b1, 1'b1, 1'b0);
      do_read("collide rd", 8'd0, 2, 8'h31, 1'b0);

      // Chip select drops with WR still high: write discarded silently
      do_write("drop", 8'd0, 8'h45, 3, 1'b1, 1'b0, 1'b0, 1'b0);
      do_read("drop rd", 8'd0, 2, 8'h31, 1'b0);

      // Strobes with chip select low are ignored
      pulses = 0;
      RD = 1'b1; WR = 1'b1; data_in = 8'h05;
      repeat (3) begin step(); if (rd_valid || wr_done || err) pulses++; end
      RD = 1'b0; WR = 1'b0;
      repeat (3) begin step(); if (rd_valid || wr_done || err) pulses++; end
      chk("no-cs strobes", 32'(pulses), 32'd0);
      do_read("no-cs rd", 8'd0, 2, 8'h31, 1'b0);

      // Reset while in RDH with rd_valid high
      camb_fecha = 1'b1; dir_in = 8'd9;
      step();
      RD = 1'b1;
      step();
      step();
      chk("pre-reset rd_valid", 32'(rd_valid), 32'd1);
      reset = 1'b1;
      #1;
      chk("mid reset data_out", 32'(data_out), 32'h0);
      chk("mid reset rd_valid", 32'(rd_valid), 32'h0);
      chk("mid reset wr_done", 32'(wr_done), 32'h0);
      chk("mid reset err", 32'(err), 32'h0);
      RD = 1'b0; camb_fecha = 1'b0;
      step();
      reset = 1'b0;
      step();
      do_read("post-reset sec", 8'd0, 2, 8'h00, 1'b0);
      do_read("post-reset day", 8'd8, 2, 8'h01, 1'b0);
      do_read("post-reset year", 8'd10, 1, 8'h00, 1'b0);

      // Random traffic against the reference model
      model_reset();
      for (int i = 0; i < 80; i++) begin
         kind = int'($urandom_range(0, 3));
         ra = ($urandom_range(0, 6) < 6) ? addr_list[$urandom_range(0, 5)]
                                         : 8'($urandom_range(0, 15));
         hold = int'($urandom_range(1, 4));
         case (kind)
            0, 1: begin
               mr = model_read(ra);
               do_read($sformatf("rnd%0d rd a=%0d", i, ra), ra, hold, mr[7:0], mr[8]);
            end
            2: begin
               rv  = ($urandom_range(0, 1) == 1) ? to_bcd(int'($urandom_range(0, 99)))
                                                : 8'($urandom);
               rtk = ($urandom_range(0, 3) == 0);
               mok = model_write(ra, rv);
               if (rtk) model_tick();
               do_write($sformatf("rnd%0d wr a=%0d v=%0h", i, ra, rv), ra, rv, hold,
                        1'b0, rtk, mok, ~mok);
            end
            default: begin
               ntick = int'($urandom_range(1, 3));
               repeat (ntick) begin do_tick(); model_tick(); end
               step();
            end
         endcase
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
